// File: rtl/rr_grant_fsm.sv
// Round-robin grant controller: shares one single-owner resource among N requesters,
// with a per-grant hold limit and a two-cycle release gap between owners.
module rr_grant_fsm #(
    parameter int  N        = 4,
    parameter int  MAX_HOLD = 8,
    localparam int ID_W     = (N > 2) ? $clog2(N) : 1,
    localparam int HC_W     = $clog2(MAX_HOLD + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            busy,
    output logic            timeout,
    output logic [1:0]      state_dbg
);

    // Handshake: req[i] is a level; requester i owns the resource while gnt[i] is high
    // and keeps ownership only as long as it holds req[i] high, up to MAX_HOLD cycles.

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    localparam logic [HC_W-1:0] HC_ONE  = HC_W'(1);
    localparam logic [HC_W-1:0] HC_MAX  = HC_W'(MAX_HOLD);
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(N - 1);
    localparam logic [ID_W:0]   N_WIDE  = (ID_W + 1)'(N);

    state_e          state_q, state_d;
    logic [ID_W-1:0] owner_q, owner_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
    logic            timeout_q, timeout_d;

    logic            win_valid;
    logic [ID_W-1:0] win_id;
    logic [ID_W-1:0] owner_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // First set request at or above ptr, wrapping from N-1 back to 0.
    always_comb begin : winner_search
        logic [ID_W:0] sum;
        win_valid = 1'b0;
        win_id    = '0;
        sum       = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_q} + (ID_W + 1)'(i);
            if (sum >= N_WIDE) begin
                sum = sum - N_WIDE;
            end
            if (!win_valid && req[sum[ID_W-1:0]]) begin
                win_valid = 1'b1;
                win_id    = sum[ID_W-1:0];
            end
        end
    end

    assign owner_next = (owner_q == ID_LAST) ? '0 : owner_q + ID_W'(1);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d    = ST_GRANT;
                    owner_d    = win_id;
                    hold_cnt_d = HC_ONE;
                end
            end
            ST_GRANT: begin
                // A voluntary drop wins over the hold limit when both happen together.
                if (!req[owner_q]) begin
                    state_d = ST_RELEASE;
                end else if (hold_cnt_q == HC_MAX) begin
                    state_d   = ST_RELEASE;
                    timeout_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HC_ONE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                ptr_d   = owner_next;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        gnt       = '0;
        gnt_id    = '0;
        busy      = 1'b0;
        timeout   = timeout_q;
        state_dbg = state_q;
        if (state_q == ST_GRANT) begin
            gnt[owner_q] = 1'b1;
            gnt_id       = owner_q;
            busy         = 1'b1;
        end
    end

endmodule

// File: doc/rr_grant_fsm.md
# rr_grant_fsm

Round-robin grant controller that shares one single-owner resource among N requesters. It sits in front of the shared datapath. Each cycle it either arbitrates, holds the current grant, or inserts a release gap. A per-grant hold limit stops any one requester from monopolising the resource. The forced release is flagged on a timeout pulse.

## Interface
- N, default 4: number of requesters; legal range 2..16.
- MAX_HOLD, default 8: maximum cycles a grant is held; legal range 2..255.
- clk  input  1  rising-edge clock; all state changes on this edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit i high while requester i wants the resource.
- gnt  output  N  one-hot grant; all zero when no one owns the resource.
- gnt_id  output  max(1,$clog2(N))  index of the current owner; 0 when gnt is zero.
- busy  output  1  high while gnt is nonzero.
- timeout  output  1  one-cycle pulse when a grant is ended by the hold limit.

## Operation
- States:
  - IDLE: no owner.
  - GRANT: one owner holds the resource.
  - RELEASE: one-cycle turnaround with no owner.
- Registers:
  - state.
  - owner (gnt_id width).
  - ptr (gnt_id width), the round-robin start index.
  - hold_cnt, width $clog2(MAX_HOLD+1).
  - timeout flag.
- All outputs are registered or decoded from registered state only. There is no combinational path from req to any output.
- IDLE:
  - If req is zero, stay in IDLE.
  - Otherwise choose the winner: the first set bit of req, searching upward from ptr and wrapping N-1 to 0.
  - Next cycle: state is GRANT, owner is the winner, hold_cnt is 1.
- GRANT, evaluated in priority order:
  - If req[owner] is 0, go to RELEASE with timeout 0.
  - Else if hold_cnt equals MAX_HOLD, go to RELEASE with timeout 1.
  - Else stay in GRANT and increment hold_cnt.
  - Requests from other requesters never pre-empt the owner.
- RELEASE:
  - gnt is zero.
  - ptr becomes (owner+1) mod N.
  - Next state is IDLE.
  - timeout is high only in the RELEASE cycle that follows a hold-limit expiry.
- Output decode:
  - gnt = onehot(owner) in GRANT, zero otherwise.
  - gnt_id = owner in GRANT, 0 otherwise.
  - busy = (state == GRANT).
- Reset takes priority over everything, including mid-grant. After reset:
  - state is IDLE; owner, ptr and hold_cnt are 0.
  - gnt is 0, gnt_id is 0, busy is 0, timeout is 0.
- Any state encoding outside the three legal states must return to IDLE.

## Timing
- Grant latency: req seen high in IDLE at edge k gives gnt high after edge k+1.
- A grant lasts 1..MAX_HOLD cycles. It is exactly MAX_HOLD cycles when the owner keeps req high.
- Gap between consecutive grants:
  - 1 RELEASE cycle plus 1 IDLE cycle, so 2 cycles with gnt zero.
  - The IDLE cycle arbitrates with the updated ptr.
- Fairness: with all N requesters permanently high, each is granted once every N*(MAX_HOLD+2) cycles, in order ptr, ptr+1, …
- Simultaneous events:
  - Owner dropping req on the same cycle hold_cnt equals MAX_HOLD is a normal release, timeout 0.
  - An owner that re-requests in the cycle after RELEASE competes normally. It is lowest priority because ptr has moved past it.
- A single requester held high continuously is re-granted after every 2-cycle gap, with a timeout pulse each period.

## Test plan
- Reset with req=4'b1111 held:
  - gnt=0, busy=0, timeout=0 throughout reset.
  - First grant is to req0, one cycle after reset deasserts.
- Single short request: req=4'b0100 for 3 cycles starting in IDLE.
  - gnt=4'b0100 and gnt_id=2 for exactly 3 cycles, starting one cycle later.
  - Then a RELEASE cycle with timeout=0.
- Hold limit: req0 held high for 20 cycles, MAX_HOLD=8.
  - Grants of exactly 8 cycles, each followed by 2 zero cycles.
  - A timeout pulse in each RELEASE cycle.
- Round-robin: req=4'b1111 constant.
  - Grant order is 0,1,2,3,0.
  - Each grant lasts 8 cycles with 2-cycle gaps.
  - Never two bits of gnt high at once.
- Wrap and skip: ptr=3 after a grant to 2, then req=4'b0011.
  - Next grant is to req0; after it, req1.
- Mid-grant reset: reset asserted in the 4th cycle of a grant to req1.
  - gnt=0 on the next edge.
  - ptr=0, so with req=4'b0011 held the following grant is to req0.
